// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, per-channel shadow duties committed at the period boundary.
// Optional build macro PWM_DITHER_EN adds a per-channel fractional-duty accumulator (first-order dither).
module pwm_multi #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 2,
    parameter int FRAC_BITS = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       CLK_SYS,
    input  logic                       CLK_RST,
    input  logic                       PWM_En,
    input  logic [WIDTH-1:0]           PWM_Period,
    input  logic                       Duty_Wr,
    input  logic [CH_W-1:0]            Duty_Ch,
    input  logic [WIDTH+FRAC_BITS-1:0] Duty_Data,
    output logic [CHANNELS-1:0]        Duty_Pending,
    output logic                       Period_Start,
    output logic [CHANNELS-1:0]        PWM_Out
);

    localparam int DW = WIDTH + FRAC_BITS;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_periodAct;
    logic [WIDTH-1:0] w_periodEff;
    logic             w_wrap;
    logic             w_commit;
    logic             r_periodStart;

    // Periods shorter than 2 would leave no room for a low phase, so they are clamped.
    assign w_periodEff = (r_periodAct < WIDTH'(2)) ? WIDTH'(2) : r_periodAct;
    assign w_wrap      = (r_cnt == (w_periodEff - WIDTH'(1)));
    assign w_commit    = !PWM_En || w_wrap;

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_cnt         <= '0;
            r_periodAct   <= '1;
            r_periodStart <= 1'b0;
        end else begin
            if (!PWM_En || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
            if (w_commit) begin
                r_periodAct <= PWM_Period;
            end
            r_periodStart <= PWM_En && (r_cnt == '0);
        end
    end

    assign Period_Start = r_periodStart;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DW-1:0]    r_shadow;
        logic [DW-1:0]    r_dutyAct;
        logic             r_pending;
        logic             r_out;
        logic             w_wrHit;
        logic [WIDTH-1:0] w_dutyInt;
        logic [WIDTH-1:0] w_dutyEff;

        assign w_wrHit   = Duty_Wr && (Duty_Ch == CH_W'(g));
        assign w_dutyInt = r_dutyAct[DW-1:FRAC_BITS];

        // A write in the commit cycle wins over the commit, so it stays pending for the next boundary.
        always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
            if (!CLK_RST) begin
                r_shadow  <= '0;
                r_dutyAct <= '0;
                r_pending <= 1'b0;
            end else if (w_wrHit) begin
                r_shadow  <= Duty_Data;
                r_pending <= 1'b1;
            end else if (w_commit && r_pending) begin
                r_dutyAct <= r_shadow;
                r_pending <= 1'b0;
            end
        end

`ifdef PWM_DITHER_EN
        logic [FRAC_BITS-1:0] r_acc;
        logic                 r_carry;

        always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
            if (!CLK_RST) begin
                r_acc   <= '0;
                r_carry <= 1'b0;
            end else if (w_commit) begin
                {r_carry, r_acc} <= {1'b0, r_acc} + {1'b0, r_dutyAct[FRAC_BITS-1:0]};
            end
        end

        assign w_dutyEff = (r_carry && (w_dutyInt != '1)) ? (w_dutyInt + WIDTH'(1)) : w_dutyInt;
`else
        logic w_unusedFrac;

        assign w_unusedFrac = ^r_dutyAct[FRAC_BITS-1:0];
        assign w_dutyEff    = w_dutyInt;
`endif

        always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
            if (!CLK_RST) begin
                r_out <= 1'b0;
            end else begin
                r_out <= PWM_En && (r_cnt < w_dutyEff);
            end
        end

        assign PWM_Out[g]      = r_out;
        assign Duty_Pending[g] = r_pending;
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus queues per-period expectations, a negedge monitor measures each period.
// Expected high counts for the dither case depend on the PWM_DITHER_EN build macro.
module tb_pwm_multi;

    logic        CLK_SYS = 1'b0;
    logic        CLK_RST = 1'b0;
    logic        PWM_En;
    logic [15:0] PWM_Period;
    logic        Duty_Wr;
    logic [0:0]  Duty_Ch;
    logic [19:0] Duty_Data;
    logic [1:0]  Duty_Pending;
    logic        Period_Start;
    logic [1:0]  PWM_Out;

    typedef struct {
        int len;
        int high0;
        int high1;
    } periodExp_t;

    periodExp_t expQ[$];
    periodExp_t curExp;
    bit         active = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         mLen = 0;
    int         mHigh[2];
    bit         mLowSeen[2];
    bit         mGlitch[2];

    pwm_multi #(.WIDTH(16), .CHANNELS(2), .FRAC_BITS(4)) dut (
        .CLK_SYS      (CLK_SYS),
        .CLK_RST      (CLK_RST),
        .PWM_En       (PWM_En),
        .PWM_Period   (PWM_Period),
        .Duty_Wr      (Duty_Wr),
        .Duty_Ch      (Duty_Ch),
        .Duty_Data    (Duty_Data),
        .Duty_Pending (Duty_Pending),
        .Period_Start (Period_Start),
        .PWM_Out      (PWM_Out)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Each Period_Start closes the measured period, compares it if it had an expectation, and opens the next.
    always @(negedge CLK_SYS) begin
        if (Period_Start === 1'b1) begin
            if (active) begin
                checkOutput("period length", mLen, curExp.len);
                checkOutput("ch0 high cycles", mHigh[0], curExp.high0);
                checkOutput("ch1 high cycles", mHigh[1], curExp.high1);
                checkOutput("high phase contiguous", int'(mGlitch[0] | mGlitch[1]), 0);
                active = 1'b0;
            end
            if (expQ.size() > 0) begin
                curExp = expQ.pop_front();
                active = 1'b1;
            end
            mLen = 1;
            for (int c = 0; c < 2; c++) begin
                mHigh[c]    = int'(PWM_Out[c]);
                mLowSeen[c] = !PWM_Out[c];
                mGlitch[c]  = 1'b0;
            end
        end else begin
            mLen++;
            for (int c = 0; c < 2; c++) begin
                if (PWM_Out[c] === 1'b1) begin
                    mHigh[c]++;
                    if (mLowSeen[c]) mGlitch[c] = 1'b1;
                end else begin
                    mLowSeen[c] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK_SYS);
        #1;
    endtask

    task automatic waitStart();
        int n = 0;
        do begin
            tick();
            n++;
        end while (Period_Start !== 1'b1 && n < 100);
        checkOutput("period start seen", int'(Period_Start === 1'b1), 1);
    endtask

    task automatic expectPeriod(input int len, input int h0, input int h1);
        periodExp_t e;
        e.len   = len;
        e.high0 = h0;
        e.high1 = h1;
        expQ.push_back(e);
    endtask

    task automatic writeDuty(input int ch, input int intPart, input int frac);
        Duty_Wr   = 1'b1;
        Duty_Ch   = ch[0:0];
        Duty_Data = {intPart[15:0], frac[3:0]};
        tick();
        Duty_Wr   = 1'b0;
    endtask

    // Reconfigure through the disabled state, where period and pending shadows commit every cycle.
    task automatic applyStimulus(input int period, input int d0, input int d1, input int f0);
        PWM_En     = 1'b0;
        PWM_Period = period[15:0];
        tick();
        writeDuty(0, d0, f0);
        writeDuty(1, d1, 0);
        tick();
        checkOutput("pending after disabled commit", int'(Duty_Pending), 0);
        checkOutput("outputs low while disabled", int'({PWM_Out, Period_Start}), 0);
        PWM_En = 1'b1;
    endtask

    task automatic runPeriods(input int n, input int len, input int h0, input int h1);
        for (int k = 0; k < n; k++) begin
            waitStart();
            expectPeriod(len, h0, h1);
        end
        waitStart();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired: got running, want finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int psCount;
        int highCount;

        PWM_En     = 1'b1;
        PWM_Period = 16'hFFFF;
        Duty_Wr    = 1'b0;
        Duty_Ch    = '0;
        Duty_Data  = '0;

        // Reset held with the PWM enabled, then the default all-ones period with duty 0.
        repeat (3) tick();
        checkOutput("reset PWM_Out", int'(PWM_Out), 0);
        checkOutput("reset Period_Start", int'(Period_Start), 0);
        checkOutput("reset Duty_Pending", int'(Duty_Pending), 0);
        CLK_RST   = 1'b1;
        psCount   = 0;
        highCount = 0;
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (Period_Start === 1'b1) psCount++;
            if (PWM_Out !== 2'b00) highCount++;
        end
        checkOutput("default period starts in 70000 cycles", psCount, 2);
        checkOutput("duty 0 high cycles after reset", highCount, 0);

        // Basic PWM.
        applyStimulus(10, 3, 7, 0);
        runPeriods(4, 10, 3, 7);

        // Glitch-free update mid-period; the second of two writes wins.
        waitStart();
        expectPeriod(10, 3, 7);
        repeat (4) tick();
        writeDuty(0, 5, 0);
        writeDuty(0, 8, 0);
        checkOutput("pending after mid-period write", int'(Duty_Pending[0]), 1);
        repeat (2) tick();
        checkOutput("pending at wrap cycle", int'(Duty_Pending[0]), 1);
        tick();
        checkOutput("pending cleared after wrap", int'(Duty_Pending[0]), 0);
        runPeriods(2, 10, 8, 7);

        // Boundary duties and the minimum period.
        applyStimulus(10, 0, 10, 0);
        runPeriods(3, 10, 0, 10);
        applyStimulus(10, 0, 15, 0);
        runPeriods(3, 10, 0, 10);
        applyStimulus(1, 1, 15, 0);
        runPeriods(3, 2, 1, 2);

        // Write landing exactly in the wrap cycle commits one boundary later.
        applyStimulus(10, 3, 7, 0);
        waitStart();
        expectPeriod(10, 3, 7);
        repeat (8) tick();
        writeDuty(0, 6, 0);
        waitStart();
        expectPeriod(10, 3, 7);
        checkOutput("wrap write still pending", int'(Duty_Pending[0]), 1);
        repeat (8) tick();
        checkOutput("wrap write pending at next wrap", int'(Duty_Pending[0]), 1);
        tick();
        checkOutput("wrap write committed", int'(Duty_Pending[0]), 0);
        waitStart();
        expectPeriod(10, 6, 7);
        waitStart();

        // Fractional duty 3.5.
        applyStimulus(10, 3, 7, 8);
        for (int k = 0; k < 4; k++) begin
            waitStart();
`ifdef PWM_DITHER_EN
            expectPeriod(10, (k % 2 == 1) ? 4 : 3, 7);
`else
            expectPeriod(10, 3, 7);
`endif
        end
        waitStart();

        // Asynchronous reset in the middle of a period.
        checkOutput("ch1 high before reset", int'(PWM_Out[1]), 1);
        writeDuty(0, 9, 0);
        checkOutput("pending before reset", int'(Duty_Pending[0]), 1);
        #2;
        CLK_RST = 1'b0;
        #1;
        checkOutput("async reset PWM_Out", int'(PWM_Out), 0);
        checkOutput("async reset Duty_Pending", int'(Duty_Pending), 0);
        checkOutput("async reset Period_Start", int'(Period_Start), 0);
        CLK_RST = 1'b1;
        tick();
        checkOutput("start pulse after reset release", int'(Period_Start), 1);

        checkOutput("scoreboard drained", expQ.size() + int'(active), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
